dsp_mem_readback: RTL and testbench
===================================

Name: dsp_mem_readback

Overview:
Host-side read responder for the per-unit DSP memory space; the read counterpart of the broadcast mem_write bus. It accepts one read request at a time on a valid/ready port and decodes the unit/cmd-wave address. It then pulses a one-hot per-unit read enable, waits a fixed memory latency and returns the word on a valid/ready response port. It sits beside the write fan-out and shares its address map.

Parameters:
DATA_WIDTH, 32, memory word width
N_DSP_UNIT, 2, number of DSP units; must be >= 2
RD_LATENCY, 2, cycles from mem_read_en to valid mem_read_data; must be >= 1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
rd_req_addr  in  13+clog2(N_DSP_UNIT)  [12+L:13] unit sel; [12] 0=cmd/1=wave; [11:0] wave addr, or cmd: [11:10] reserved, [9:8] cmd_sel, [7:0] buffer addr
rd_req_valid  in  1  request valid
rd_req_ready  out  1  request accepted when valid&ready
rd_resp_data  out  DATA_WIDTH  read word; 0 on error
rd_resp_err  out  1  decode error flag
rd_resp_valid  out  1  response valid
rd_resp_ready  in  1  response consumed when valid&ready
mem_read_addr  out  13  local address [12:0] broadcast to all units
mem_read_en  out  N_DSP_UNIT  one-hot single-cycle read strobe
mem_read_data  in  N_DSP_UNIT*DATA_WIDTH  unit i word at [i*DATA_WIDTH +: DATA_WIDTH]
mem_write_addr  in  13+clog2(N_DSP_UNIT)  concurrent write address (collision check)
mem_write_en  in  1  concurrent write strobe

Behaviour:
- All outputs are registered; reset asserted (reset=0) forces state IDLE and all outputs to 0. rd_req_ready rises on the first clk edge after reset release.
- Reset mid-transaction abandons it: no strobe or response is produced afterwards.
- FSM IDLE -> ISSUE | RESP; ISSUE -> ISSUE (stall) | WAIT; WAIT -> RESP; RESP -> IDLE.
- IDLE: rd_req_ready=1. On valid&ready in cycle T, latch the address and drop ready.
  - Decode error: unit sel >= N_DSP_UNIT, or cmd space (bit12=0) with reserved bits [11:10] != 0. Go to RESP with err=1 and data=0; no mem_read_en is issued. rd_resp_valid is high from cycle T+1.
  - Otherwise go to ISSUE.
- ISSUE: if mem_write_en=1 and mem_write_addr unit sel equals the latched unit, stall one cycle with no strobe. Else assert mem_read_en[unit]=1 and mem_read_addr=latched[12:0] for exactly one cycle, load the counter with RD_LATENCY, and go to WAIT.
- WAIT: the counter decrements each cycle. In the cycle RD_LATENCY after the strobe, the selected mem_read_data slice is captured. Enter RESP with err=0.
- Uncontended latency: strobe at T+1; rd_resp_valid high from T+2+RD_LATENCY.
- RESP: rd_resp_valid=1. rd_resp_data and rd_resp_err stay stable while rd_resp_ready=0. On handshake, valid drops and the next cycle is IDLE with ready=1.
- Only one request is outstanding at a time. mem_read_en is 0 outside ISSUE, and mem_read_addr holds its last value.
- A simultaneous write to a different unit does not stall the read.
- A write to the same unit during WAIT does not affect the read; the captured data is whatever the memory returns.

Test Plan:
- N=2, L=2: read unit1 wave addr 0x005 (req addr 0x3005) with unit1 returning 0xDEADBEEF -> mem_read_en=2'b10 at T+1, mem_read_addr=0x1005, resp valid at T+4, data 0xDEADBEEF, err=0.
- Read cmd space with reserved bits set (addr 0x0C10) -> no mem_read_en, resp at T+1 with err=1, data=0.
- N=3: request with unit sel=3 -> err=1, no strobe; unit sel=2 succeeds normally.
- Read unit0 while mem_write_en=1 targeting unit0 for 3 cycles -> strobe delayed 3 cycles, response correct. Repeat with the write targeting unit1 -> no delay.
- Hold rd_resp_ready=0 for 5 cycles -> data/err stable and rd_req_ready=0 throughout; on release, ready returns the following cycle.
- Assert reset during WAIT -> all outputs 0 immediately, no response afterwards, and a fresh read after release completes correctly.

Source files
------------

// File: rtl/dsp_mem_readback.sv
// Host-side read responder for the per-unit DSP memory space. It decodes a
// unit/cmd-wave address, strobes the owning unit, waits out the memory latency
// and returns the word.

module dsp_mem_readback #(
    parameter int DATA_WIDTH = 32,
    parameter int N_DSP_UNIT = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [13+$clog2(N_DSP_UNIT)-1:0]   rd_req_addr,
    input  logic                               rd_req_valid,
    output logic                               rd_req_ready,
    output logic [DATA_WIDTH-1:0]              rd_resp_data,
    output logic                               rd_resp_err,
    output logic                               rd_resp_valid,
    input  logic                               rd_resp_ready,
    output logic [12:0]                        mem_read_addr,
    output logic [N_DSP_UNIT-1:0]              mem_read_en,
    input  logic [N_DSP_UNIT*DATA_WIDTH-1:0]   mem_read_data,
    input  logic [13+$clog2(N_DSP_UNIT)-1:0]   mem_write_addr,
    input  logic                               mem_write_en
);
    localparam int UW = $clog2(N_DSP_UNIT);
    localparam int AW = 13 + UW;
    localparam int CW = $clog2(RD_LATENCY + 1);
    localparam logic [UW:0] N_UNITS = (UW+1)'(N_DSP_UNIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [UW-1:0]           unit_q, unit_d;
    logic [12:0]             local_q, local_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    req_ready_d, resp_valid_d, resp_err_d, strobe_d;
    logic [DATA_WIDTH-1:0]   resp_data_d, sel_data;
    logic [12:0]             rd_addr_d;
    logic [N_DSP_UNIT-1:0]   rd_en_d;

    logic [UW-1:0] req_unit, wr_unit;
    logic          req_err;
    logic          unused_wr_local;

    assign req_unit        = rd_req_addr[AW-1:13];
    assign wr_unit         = mem_write_addr[AW-1:13];
    assign unused_wr_local = ^mem_write_addr[12:0];
    assign req_err = ({1'b0, req_unit} >= N_UNITS) ||
                     (!rd_req_addr[12] && rd_req_addr[11:10] != 2'b00);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_DSP_UNIT; i++) begin
            if (unit_q == UW'(i)) sel_data = mem_read_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // The collision check looks at the write bus in the cycle before the strobe
    // cycle, so that mem_read_en can leave the block straight from a flop.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d      = state_q;
        unit_d       = unit_q;
        local_d      = local_q;
        cnt_d        = cnt_q;
        req_ready_d  = rd_req_ready;
        resp_valid_d = rd_resp_valid;
        resp_err_d   = rd_resp_err;
        resp_data_d  = rd_resp_data;
        rd_addr_d    = mem_read_addr;
        strobe_d     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (rd_req_valid && rd_req_ready) begin
                    req_ready_d = 1'b0;
                    unit_d      = req_unit;
                    local_d     = rd_req_addr[12:0];
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                    end else begin
                        state_d  = ISSUE;
                        strobe_d = !(mem_write_en && wr_unit == req_unit);
                        if (strobe_d) rd_addr_d = rd_req_addr[12:0];
                    end
                end
            end
            ISSUE: begin
                if (|mem_read_en) begin
                    state_d = WAIT;
                    cnt_d   = CW'(RD_LATENCY);
                end else if (!(mem_write_en && wr_unit == unit_q)) begin
                    strobe_d  = 1'b1;
                    rd_addr_d = local_q;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = sel_data;
                end
            end
            RESP: begin
                if (rd_resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        for (int i = 0; i < N_DSP_UNIT; i++) begin
            rd_en_d[i] = strobe_d && (unit_d == UW'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            unit_q        <= '0;
            local_q       <= '0;
            cnt_q         <= '0;
            rd_req_ready  <= 1'b0;
            rd_resp_valid <= 1'b0;
            rd_resp_err   <= 1'b0;
            rd_resp_data  <= '0;
            mem_read_en   <= '0;
            mem_read_addr <= '0;
        end else begin
            state_q       <= state_d;
            unit_q        <= unit_d;
            local_q       <= local_d;
            cnt_q         <= cnt_d;
            rd_req_ready  <= req_ready_d;
            rd_resp_valid <= resp_valid_d;
            rd_resp_err   <= resp_err_d;
            rd_resp_data  <= resp_data_d;
            mem_read_en   <= rd_en_d;
            mem_read_addr <= rd_addr_d;
        end
    end

endmodule

// File: tb/tb_dsp_mem_readback.sv
// Bench for dsp_mem_readback: a directed vector table, random reads checked
// against an address-rule model with a latency-accurate memory, plus N=3 and reset cases.

module tb_dsp_mem_readback;
    localparam int DW = 32;
    localparam int N  = 2;
    localparam int L  = 2;
    localparam int AW = 14;
    localparam int N3 = 3;
    localparam int L3 = 1;
    localparam int AW3 = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // main instance (N=2, L=2)
    logic [AW-1:0]   rd_req_addr = '0;
    logic            rd_req_valid = 1'b0;
    logic            rd_req_ready;
    logic [DW-1:0]   rd_resp_data;
    logic            rd_resp_err, rd_resp_valid;
    logic            rd_resp_ready = 1'b1;
    logic [12:0]     mem_read_addr;
    logic [N-1:0]    mem_read_en;
    logic [N*DW-1:0] mem_read_data;
    logic [AW-1:0]   mem_write_addr = '0;
    logic            mem_write_en = 1'b0;

    // second instance (N=3, L=1)
    logic [AW3-1:0]   rd_req_addr3 = '0;
    logic             rd_req_valid3 = 1'b0;
    logic             rd_req_ready3;
    logic [DW-1:0]    rd_resp_data3;
    logic             rd_resp_err3, rd_resp_valid3;
    logic [12:0]      mem_read_addr3;
    logic [N3-1:0]    mem_read_en3;
    logic [N3*DW-1:0] mem_read_data3 = {32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};

    dsp_mem_readback #(.DATA_WIDTH(DW), .N_DSP_UNIT(N), .RD_LATENCY(L)) u_dut (
        .clk(clk), .reset(reset),
        .rd_req_addr(rd_req_addr), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .mem_read_addr(mem_read_addr), .mem_read_en(mem_read_en), .mem_read_data(mem_read_data),
        .mem_write_addr(mem_write_addr), .mem_write_en(mem_write_en)
    );

    dsp_mem_readback #(.DATA_WIDTH(DW), .N_DSP_UNIT(N3), .RD_LATENCY(L3)) u_dut3 (
        .clk(clk), .reset(reset),
        .rd_req_addr(rd_req_addr3), .rd_req_valid(rd_req_valid3), .rd_req_ready(rd_req_ready3),
        .rd_resp_data(rd_resp_data3), .rd_resp_err(rd_resp_err3),
        .rd_resp_valid(rd_resp_valid3), .rd_resp_ready(1'b1),
        .mem_read_addr(mem_read_addr3), .mem_read_en(mem_read_en3), .mem_read_data(mem_read_data3),
        .mem_write_addr(15'h0000), .mem_write_en(1'b0)
    );

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: each unit's word appears on its slice only in the cycle
    // exactly L cycles after the strobe; noise is driven at all other times.
    logic [DW-1:0] mem [N][8192];
    typedef struct { int due; int unit; logic [12:0] addr; } pend_t;
    pend_t pend[$];

    always @(negedge clk) begin
        logic [N*DW-1:0] bus;
        for (int i = 0; i < N; i++)
            if (mem_read_en[i]) pend.push_back('{cyc + L, i, mem_read_addr});
        while (pend.size() > 0 && pend[0].due < cyc) pend.delete(0);
        for (int i = 0; i < N; i++) bus[i*DW +: DW] = $urandom;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            bus[pend[0].unit*DW +: DW] = mem[pend[0].unit][pend[0].addr];
            pend.delete(0);
        end
        mem_read_data = bus;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected outcome straight from the address rules; offsets count cycles from acceptance.
    function automatic void model(input logic [AW-1:0] a, input int wr_len, input int wr_unit,
                                  output logic err, output logic [31:0] data,
                                  output int strobe, output int resp);
        int unit = int'(a[AW-1:13]);
        err = (unit >= N) || (a[12] == 1'b0 && a[11:10] != 2'b00);
        if (err) begin
            data = 0; strobe = 0; resp = 1;
        end else begin
            data   = mem[unit][a[12:0]];
            strobe = 1 + ((wr_len > 0 && wr_unit == unit) ? wr_len : 0);
            resp   = strobe + L + 1;
        end
    endfunction

    // One read on the main instance, called at a negedge; writes are driven in
    // cycles T..T+wr_len-1 where T is the acceptance cycle.
    task automatic do_read(input logic [AW-1:0] a, input int wr_len, input int wr_unit,
                           input int stall, input logic exp_err, input logic [31:0] exp_data,
                           input int exp_strobe, input int exp_resp);
        int unit = int'(a[AW-1:13]);
        int w = 0;
        logic [N-1:0] onehot;
        while (!rd_req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_idle", 32'(rd_req_ready), 32'd1);
        rd_req_addr    = a;
        rd_req_valid   = 1'b1;
        mem_write_en   = (wr_len > 0);
        mem_write_addr = {wr_unit[0], 13'($urandom)};
        for (int k = 1; k <= exp_resp + stall + 1; k++) begin
            @(negedge clk);
            rd_req_valid = 1'b0;
            rd_req_addr  = AW'($urandom);
            onehot = (k == exp_strobe && !exp_err) ? (N'(1) << unit) : '0;
            check("mem_read_en", 32'(mem_read_en), 32'(onehot));
            if (k == exp_strobe) check("mem_read_addr", 32'(mem_read_addr), 32'(a[12:0]));
            if (k <= exp_resp + stall) check("req_ready_busy", 32'(rd_req_ready), 32'd0);
            if (k < exp_resp) begin
                check("resp_valid_early", 32'(rd_resp_valid), 32'd0);
            end else if (k <= exp_resp + stall) begin
                check("resp_valid", 32'(rd_resp_valid), 32'd1);
                check("resp_data", rd_resp_data, exp_data);
                check("resp_err", 32'(rd_resp_err), 32'(exp_err));
            end else begin
                check("resp_valid_drop", 32'(rd_resp_valid), 32'd0);
                check("req_ready_back", 32'(rd_req_ready), 32'd1);
            end
            mem_write_en   = (k < wr_len);
            mem_write_addr = {wr_unit[0], 13'($urandom)};
            rd_resp_ready  = (k >= exp_resp + stall);
        end
    endtask

    // Observe one read on the N=3 instance and report what happened when.
    task automatic read3(input logic [AW3-1:0] a, output int strobe_k, output int en,
                         output int resp_k, output logic [31:0] data, output logic err);
        strobe_k = 0; en = 0; resp_k = 0; data = 'x; err = 1'bx;
        rd_req_addr3  = a;
        rd_req_valid3 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            rd_req_valid3 = 1'b0;
            if (mem_read_en3 != '0 && strobe_k == 0) begin
                strobe_k = k;
                en = int'(mem_read_en3);
            end
            if (rd_resp_valid3 && resp_k == 0) begin
                resp_k = k;
                data = rd_resp_data3;
                err = rd_resp_err3;
            end
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        int            wr_len;
        int            wr_unit;
        int            stall;
        logic          exp_err;
        logic [31:0]   exp_data;
        int            exp_strobe;
        int            exp_resp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic        m_err;
        logic [31:0] m_data;
        int          m_strobe, m_resp;
        int          s_k, en_v, r_k;
        logic [31:0] d3;
        logic        e3;

        for (int u = 0; u < N; u++)
            for (int i = 0; i < 8192; i++) mem[u][i] = $urandom;
        mem[1][13'h1005] = 32'hDEAD_BEEF;
        mem[0][13'h0005] = 32'h1234_5678;
        mem[0][13'h1FFF] = 32'hA5A5_0FFF;
        mem[1][13'h0300] = 32'h0BAD_F00D;

        vecs[0] = '{14'h3005, 0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1, 4};
        vecs[1] = '{14'h0C10, 0, 0, 0, 1'b1, 32'h0,         0, 1};
        vecs[2] = '{14'h0005, 0, 0, 0, 1'b0, 32'h1234_5678, 1, 4};
        vecs[3] = '{14'h0005, 3, 0, 0, 1'b0, 32'h1234_5678, 4, 7};
        vecs[4] = '{14'h0005, 3, 1, 0, 1'b0, 32'h1234_5678, 1, 4};
        vecs[5] = '{14'h1FFF, 0, 0, 5, 1'b0, 32'hA5A5_0FFF, 1, 4};
        vecs[6] = '{14'h0400, 2, 0, 2, 1'b1, 32'h0,         0, 1};
        vecs[7] = '{14'h2300, 1, 1, 0, 1'b0, 32'h0BAD_F00D, 2, 5};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(rd_req_ready), 32'd0);
        check("rst_resp_valid", 32'(rd_resp_valid), 32'd0);
        check("rst_mem_read_en", 32'(mem_read_en), 32'd0);
        check("rst_resp_data", rd_resp_data, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("req_ready_after_rst", 32'(rd_req_ready), 32'd1);

        foreach (vecs[i])
            do_read(vecs[i].addr, vecs[i].wr_len, vecs[i].wr_unit, vecs[i].stall,
                    vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_strobe, vecs[i].exp_resp);

        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] a = AW'($urandom);
            int wl = $urandom_range(0, 3);
            int wu = $urandom_range(0, 1);
            int st = $urandom_range(0, 3);
            model(a, wl, wu, m_err, m_data, m_strobe, m_resp);
            do_read(a, wl, wu, st, m_err, m_data, m_strobe, m_resp);
        end

        // N=3: unit select 3 is out of range, unit 2 and 1 decode normally
        read3(15'h6005, s_k, en_v, r_k, d3, e3);
        check("n3_bad_strobe", 32'(s_k), 32'd0);
        check("n3_bad_resp_cycle", 32'(r_k), 32'd1);
        check("n3_bad_err", 32'(e3), 32'd1);
        check("n3_bad_data", d3, 32'd0);
        read3(15'h4005, s_k, en_v, r_k, d3, e3);
        check("n3_u2_strobe", 32'(s_k), 32'd1);
        check("n3_u2_en", 32'(en_v), 32'd4);
        check("n3_u2_resp_cycle", 32'(r_k), 32'd3);
        check("n3_u2_err", 32'(e3), 32'd0);
        check("n3_u2_data", d3, 32'hCCCC_0002);
        read3(15'h3123, s_k, en_v, r_k, d3, e3);
        check("n3_u1_en", 32'(en_v), 32'd2);
        check("n3_u1_data", d3, 32'hCCCC_0001);

        // reset while waiting on the memory
        rd_req_addr  = 14'h3005;
        rd_req_valid = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b0;
        check("rstw_strobe", 32'(mem_read_en), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstw_req_ready", 32'(rd_req_ready), 32'd0);
        check("rstw_resp_valid", 32'(rd_resp_valid), 32'd0);
        check("rstw_mem_read_en", 32'(mem_read_en), 32'd0);
        check("rstw_mem_read_addr", 32'(mem_read_addr), 32'd0);
        check("rstw_resp_data", rd_resp_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rstw_no_resp", 32'(rd_resp_valid), 32'd0);
            check("rstw_no_strobe", 32'(mem_read_en), 32'd0);
            check("rstw_ready", 32'(rd_req_ready), 32'd1);
        end
        do_read(14'h3005, 0, 0, 1, 1'b0, 32'hDEAD_BEEF, 1, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
